// File: rtl/dmem_if.sv
// Core MEM-stage to data-memory handshake bundle.
// The master side drives the request and the slave returns data, done, stall and err.
interface dmem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;
    logic                  done;
    logic                  stall;
    logic                  err;

    modport master (
        output req, we, be, addr, wdata,
        input  rdata, done, stall, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, done, stall, err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word array with byte-enabled stores, WAIT_STATES delay and stall/done handshake.
// Optional out-of-range suppression and err flag when DMEM_RANGE_CHECK_EN is defined.
//
// state  | meaning
// IDLE   | waiting for req; accepting latches the request and loads the wait counter
// ACCESS | counting wait states; array op on the edge where cnt==0
// DONE   | one-cycle completion pulse; req not accepted here
module dmem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                we_q;
    logic [NB-1:0]       be_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                oor_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                done_q;
    logic                err_q;
    logic                req_oor;
    logic                do_op;

    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef DMEM_RANGE_CHECK_EN
    assign req_oor = |bus.addr[ADDR_W-1:IDX_W+2];
`else
    assign req_oor = 1'b0;
`endif

    assign do_op = (state == ACCESS) && (cnt == 4'd0) && !oor_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        be_q    <= bus.be;
                        idx_q   <= bus.addr[IDX_W+1:2];
                        wdata_q <= bus.wdata;
                        oor_q   <= req_oor;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        err_q  <= oor_q;
                        if (!we_q)
                            rdata_q <= oor_q ? '0 : mem[idx_q];
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array is deliberately not reset; an async reset drops state out of ACCESS, cancelling pending stores.
    always_ff @(posedge clk) begin
        if (do_op && we_q) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i])
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.stall = !rst && (((state == IDLE) && bus.req) || (state == ACCESS));
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with WAIT_STATES=0 and one with WAIT_STATES=3.
// Expectations are hand-computed constants.
module tb_dmem_ctrl;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, sel;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          t_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_if #(.DATA_W(32), .ADDR_W(32)) if0 ();
    dmem_if #(.DATA_W(32), .ADDR_W(32)) if3 ();

    assign if0.req = req & ~sel;
    assign if0.we = we;  assign if0.be = be;  assign if0.addr = addr;  assign if0.wdata = wdata;
    assign if3.req = req & sel;
    assign if3.we = we;  assign if3.be = be;  assign if3.addr = addr;  assign if3.wdata = wdata;

    dmem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    dmem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic        m_done, m_stall, m_err;
    logic [31:0] m_rdata;
    assign m_done  = sel ? if3.done  : if0.done;
    assign m_stall = sel ? if3.stall : if0.stall;
    assign m_err   = sel ? if3.err   : if0.err;
    assign m_rdata = sel ? if3.rdata : if0.rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Call just after a rising edge; returns done cycle index (0 = first req-high cycle).
    task automatic access(input bit w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, output int lat, output int nst,
                          output logic [31:0] rd, output logic er);
        we = w; be = b; addr = a; wdata = d; req = 1'b1;
        lat = -1; nst = 0; rd = '0; er = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_stall) nst++;
            if (m_done) begin
                lat = k; rd = m_rdata; er = m_err; t_done = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
    endtask

    int          lat, nst, t1, npulse;
    logic [31:0] rd;
    logic        er;

    initial begin
        rst = 1'b1; req = 1'b1; we = 1'b0; be = 4'h0; addr = '0; wdata = '0; sel = 1'b0;
        @(negedge clk);
        chk("stall_in_rst0", {31'd0, if0.stall}, 32'd0);
        chk("stall_in_rst3", {31'd0, if3.stall}, 32'd0);
        req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_rdata", m_rdata, 32'd0);
            chk("idle_done", {31'd0, m_done}, 32'd0);
            chk("idle_stall", {31'd0, m_stall}, 32'd0);
            chk("idle_err", {31'd0, m_err}, 32'd0);
        end
        @(posedge clk); #1;

        // WAIT_STATES=0
        access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, lat, nst, rd, er);
        chk("ws0_st_lat", lat, 32'd2);
        chk("ws0_st_stall", nst, 32'd2);
        chk("ws0_st_err", {31'd0, er}, 32'd0);
        chk("ws0_st_rdata_held", rd, 32'd0);
        access(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, lat, nst, rd, er);
        chk("ws0_ld_lat", lat, 32'd2);
        chk("ws0_ld_stall", nst, 32'd2);
        chk("ws0_ld_data", rd, 32'hDEADBEEF);

        access(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, lat, nst, rd, er);
        access(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b0, lat, nst, rd, er);
        access(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, lat, nst, rd, er);
        chk("be_merge", rd, 32'h11BB33DD);
        access(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b0, lat, nst, rd, er);
        chk("be0_lat", lat, 32'd2);
        access(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, lat, nst, rd, er);
        chk("be0_nochange", rd, 32'h11BB33DD);

        // WAIT_STATES=3
        sel = 1'b1;
        access(1'b1, 4'hF, 32'h30, 32'h0BADF00D, 1'b0, lat, nst, rd, er);
        chk("ws3_st_lat", lat, 32'd5);
        access(1'b0, 4'h0, 32'h30, 32'h0, 1'b1, lat, nst, rd, er);
        chk("ws3_ld_lat", lat, 32'd5);
        chk("ws3_ld_stall", nst, 32'd5);
        chk("ws3_ld_data", rd, 32'h0BADF00D);
        t1 = t_done;
        access(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, lat, nst, rd, er);
        chk("b2b_lat", lat, 32'd5);
        chk("b2b_spacing", t_done - t1, 32'd6);
        chk("b2b_data_unwritten_ok", {31'd0, er}, 32'd0);

        // Reset two cycles into a store; the store must be discarded.
        access(1'b1, 4'hF, 32'h40, 32'h01020304, 1'b0, lat, nst, rd, er);
        access(1'b0, 4'h0, 32'h30, 32'h0, 1'b0, lat, nst, rd, er);
        chk("pre_rst_rdata", rd, 32'h0BADF00D);
        we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'h5555AAAA; req = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, if3.stall}, 32'd0);
        chk("rst_rdata", if3.rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if3.done) npulse++;
        end
        chk("rst_no_done", npulse, 32'd0);
        @(posedge clk); #1;
        access(1'b0, 4'h0, 32'h40, 32'h0, 1'b0, lat, nst, rd, er);
        chk("rst_store_dropped", rd, 32'h01020304);

        // Range behaviour on the WAIT_STATES=0 instance
        sel = 1'b0;
        access(1'b1, 4'hF, 32'h0, 32'h12345678, 1'b0, lat, nst, rd, er);
        chk("rng_inrange_err", {31'd0, er}, 32'd0);
        access(1'b1, 4'hF, 32'h400, 32'hCAFEF00D, 1'b0, lat, nst, rd, er);
        chk("rng_oor_err", {31'd0, er}, {31'd0, RANGE_EN});
        chk("rng_oor_lat", lat, 32'd2);
        access(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, lat, nst, rd, er);
        chk("rng_word0", rd, RANGE_EN ? 32'h12345678 : 32'hCAFEF00D);
        chk("rng_word0_err", {31'd0, er}, 32'd0);
        access(1'b0, 4'h0, 32'h400, 32'h0, 1'b0, lat, nst, rd, er);
        chk("rng_oor_load", rd, RANGE_EN ? 32'h0 : 32'hCAFEF00D);
        chk("rng_oor_load_err", {31'd0, er}, {31'd0, RANGE_EN});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller that replaces the bare single-port data RAM beside the MIPS core. Owns a word-organised storage array with byte-enabled writes and a configurable number of wait states, and returns a stall/done handshake so the pipeline freezes until each load or store completes. Sits between the core's MEM stage (address, write data, store enables) and its load-data path, on the core clock.

## Interface
- DATA_W, 32: data word width in bits; a multiple of 8.
- DEPTH, 256: number of words in the array; a power of 2, at least 2.
- ADDR_W, 32: byte-address width presented by the core.
- WAIT_STATES, 0: extra cycles inserted before the array access; range 0–15.

- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req  in  1  access request; held high by the core until the `done` cycle.
- we  in  1  1 = store, 0 = load; sampled at acceptance.
- be  in  DATA_W/8  byte enables for stores; ignored for loads.
- addr  in  ADDR_W  byte address; word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
- wdata  in  DATA_W  store data, byte lane i = wdata[8i+7:8i].
- rdata  out  DATA_W  load data; registered, valid in the `done` cycle and held until the next completion.
- done  out  1  one-cycle pulse: the accepted access has completed.
- stall  out  1  combinational freeze request to the pipeline.
- err  out  1  out-of-range flag, valid in the `done` cycle only (see Configuration).

## Operation
- States: IDLE, ACCESS, DONE. Registers: latched we/be/index/wdata, 4-bit wait counter `cnt`.
- IDLE: when req=1, latch request, load cnt=WAIT_STATES, go to ACCESS. When req=0, stay.
- ACCESS: if cnt≠0, decrement and stay. If cnt=0, perform the array operation on this edge and go to DONE:
  - store: write only lanes with be[i]=1; other lanes keep old contents; rdata unchanged.
  - load: rdata ← array[index] (full word).
- DONE: done=1, go to IDLE unconditionally; req is not accepted in DONE.
- stall = (state==IDLE & req) | (state==ACCESS); stall=0 in DONE; forced 0 while rst=1.
- Store with be=0 completes normally with no array change.
- Array contents are not initialised or cleared by reset.

## Timing
- Request sampled high in IDLE at edge E0: array access at edge E0+WAIT_STATES+1; done high in the cycle after it; total latency WAIT_STATES+2 cycles from the first req-high cycle to done.
- Back-to-back: a req held through DONE is accepted on the following IDLE cycle; throughput one access per WAIT_STATES+3 cycles.
- Reset values: state=IDLE, cnt=0, rdata=0, done=0, err=0, stall=0.
- Reset asserted mid-access: state returns to IDLE immediately; a store not yet performed is discarded; a store already performed stays in the array; no done pulse is issued for the aborted access.
- req dropped while in ACCESS: access still completes and done still pulses (protocol violation tolerated, not aborted).

## Configuration
- DMEM_RANGE_CHECK_EN defined: access whose addr[ADDR_W-1:2] ≥ DEPTH is suppressed (no write; rdata ← 0) and err=1 in its DONE cycle; in-range accesses have err=0. Latency unchanged.
- Undefined: upper address bits ignored, index wraps modulo DEPTH, err tied to 0.

## Test plan
- Reset then idle: rst 1→0, req=0 -> rdata=0, done=0, stall=0, err=0 for 10 cycles.
- WAIT_STATES=0: store 0xDEADBEEF to addr 0x10, be=4'hF, then load 0x10 -> each done 2 cycles after req rises, stall high exactly those 2 cycles, load rdata=0xDEADBEEF.
- Byte enables: word 0x20 = 0x11223344, store 0xAABBCCDD with be=4'b0101 -> load returns 0x11BB33DD.
- WAIT_STATES=3: load with req held -> stall high 5 cycles, done at cycle 5; back-to-back second load accepted next IDLE, done 6 cycles after first done.
- Reset during ACCESS of a store of 0x5555AAAA to 0x40 (WAIT_STATES=3, rst after 2 cycles) -> no done pulse, later load of 0x40 returns prior contents.
- Range (DEPTH=256): store to addr 0x400 with DMEM_RANGE_CHECK_EN -> err=1, word 0 unchanged; without macro -> err=0, load of addr 0x0 returns stored value.
